dqpsk_iq_mapper: RTL and testbench
==================================

DQPSK_IQ_MAPPER -- requirements
Module: dqpsk_iq_mapper

Interface
REQ-001 Parameter SPS, default 8, samples per symbol (clk cycles each symbol is held); legal range 2..64.
REQ-002 Parameter W, default 12, signed width of the I/Q sample outputs.
REQ-003 Parameter AMP, default 1448, positive constellation magnitude (about 0.707 of 2^(W-1)); must fit in W-1 bits.
REQ-004 clk  input  1  single clock; every register updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_code  input  2  differentially encoded dibit from diff_encode.
REQ-007 in_valid  input  1  in_code holds a symbol to transfer.
REQ-008 in_ready  output  1  mapper will accept a symbol this cycle.
REQ-009 i_out  output  W  signed in-phase sample.
REQ-010 q_out  output  W  signed quadrature sample.
REQ-011 out_valid  output  1  i_out/q_out carry a live symbol sample.
REQ-012 sym_start  output  1  single-cycle marker on the first sample of each symbol.
REQ-013 underrun  output  1  single-cycle pulse when the stream breaks at a symbol boundary.

Function
REQ-014 A transfer occurs only in a cycle where in_valid and in_ready are both 1; in_code is sampled only on a transfer.
REQ-015 Gray mapping (I,Q): 00 gives (+AMP,+AMP); 01 gives (-AMP,+AMP); 11 gives (-AMP,-AMP); 10 gives (+AMP,-AMP).
REQ-016 Two states: IDLE and RUN, plus a phase counter of ceil(log2(SPS)) bits.
REQ-017 IDLE: in_ready=1, out_valid=0, i_out=q_out=0.
REQ-018 IDLE -> RUN on a transfer.
REQ-019 Latency is exactly 1 cycle: a transfer in cycle t puts the mapped I/Q on the outputs in cycle t+1, with sym_start=1, out_valid=1 and phase=0.
REQ-020 RUN: i_out/q_out are held constant for exactly SPS cycles, with phase incrementing 0..SPS-1.
REQ-021 RUN: in_ready=1 only when phase==SPS-1.
REQ-022 Back-to-back symbols: a transfer at phase SPS-1 starts the next symbol in the following cycle (phase wraps to 0, sym_start=1) with no gap sample.
REQ-023 End of stream: if no transfer occurs at phase SPS-1, the next cycle is IDLE.
REQ-024 In that IDLE cycle: outputs are zero, out_valid=0, and underrun pulses 1 for one cycle.
REQ-025 in_valid in RUN at phase other than SPS-1 is ignored; the source must hold it.
REQ-026 in_code changing while in_ready=0 has no effect on outputs.
REQ-027 sym_start and underrun are never 1 in the same cycle.
REQ-028 Outputs are registered; no combinational path from any input to i_out, q_out, out_valid, sym_start or underrun (in_ready may depend on state only).

Reset
REQ-029 While rst=1 at a clock edge: state=IDLE, phase=0, i_out=0, q_out=0, out_valid=0, sym_start=0, underrun=0.
REQ-030 in_ready=1 in the first cycle after reset release.
REQ-031 rst asserted mid-symbol aborts that symbol immediately.
REQ-032 Reset never generates an underrun pulse.

Structure
REQ-033 Shared package dqpsk_pkg holds the dibit codes (2'b00, 2'b01, 2'b11, 2'b10) and the state encoding constants.
REQ-034 One sub-module dqpsk_sym_lut: combinational dibit -> (I,Q) using AMP and W.
REQ-035 The phase counter and state machine live in the top module.

Verification
REQ-036 rst high 3 cycles, then low -> all outputs 0, in_ready=1, no underrun pulse.
REQ-037 SPS=8, in_valid held 1 with codes 00,01,11,10 -> I/Q = (+1448,+1448), (-1448,+1448), (-1448,-1448), (+1448,-1448), each held 8 cycles; sym_start every 8th cycle; no gaps; first sample 1 cycle after the first transfer.
REQ-038 Single symbol 11 then in_valid=0 -> (-1448,-1448) for 8 cycles, then outputs 0, out_valid=0, underrun=1 for exactly one cycle.
REQ-039 in_valid toggled with changing codes at phases 2..6 -> samples unchanged; only the code present at phase 7 is taken.
REQ-040 rst=1 at phase 4 of symbol 01 -> next cycle outputs 0, state IDLE, underrun=0.
REQ-041 SPS=2, continuous random codes for 1000 symbols -> every sample matches the REQ-015 mapping delayed 1 cycle; each symbol lasts 2 cycles; no underrun.

Source files
------------

// File: rtl/dqpsk_pkg.sv
// Shared definitions for the DQPSK I/Q mapper: Gray dibit codes and FSM state encoding.
package dqpsk_pkg;

    localparam logic [1:0] DIBIT_00 = 2'b00;
    localparam logic [1:0] DIBIT_01 = 2'b01;
    localparam logic [1:0] DIBIT_11 = 2'b11;
    localparam logic [1:0] DIBIT_10 = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/dqpsk_iq_mapper_if.sv
// Symbol-in / sample-out bundle of the DQPSK I/Q mapper.
interface dqpsk_iq_mapper_if #(
    parameter int W = 12
);
    logic [1:0]          in_code;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] i_out;
    logic signed [W-1:0] q_out;
    logic                out_valid;
    logic                sym_start;
    logic                underrun;

    modport slave (
        input  in_code, in_valid,
        output in_ready, i_out, q_out, out_valid, sym_start, underrun
    );

    modport master (
        output in_code, in_valid,
        input  in_ready, i_out, q_out, out_valid, sym_start, underrun
    );
endinterface

// File: rtl/dqpsk_sym_lut.sv
// Combinational Gray dibit to constellation point lookup.
module dqpsk_sym_lut
    import dqpsk_pkg::*;
#(
    parameter int W   = 12,
    parameter int AMP = 1448
) (
    input  logic [1:0]          code_i,
    output logic signed [W-1:0] i_o,
    output logic signed [W-1:0] q_o
);
    localparam logic signed [W-1:0] POS = W'(AMP);
    localparam logic signed [W-1:0] NEG = -POS;

    always_comb begin
        i_o = POS;
        q_o = POS;
        case (code_i)
            DIBIT_00: begin i_o = POS; q_o = POS; end
            DIBIT_01: begin i_o = NEG; q_o = POS; end
            DIBIT_11: begin i_o = NEG; q_o = NEG; end
            DIBIT_10: begin i_o = POS; q_o = NEG; end
            default:  begin i_o = POS; q_o = POS; end
        endcase
    end
endmodule

// File: rtl/dqpsk_iq_mapper.sv
// DQPSK I/Q mapper: accepts one dibit per symbol and holds its constellation point for SPS cycles.
module dqpsk_iq_mapper
    import dqpsk_pkg::*;
#(
    parameter int SPS = 8,
    parameter int W   = 12,
    parameter int AMP = 1448
) (
    input  logic              clk,
    input  logic              rst,
    dqpsk_iq_mapper_if.slave  bus
);
    localparam int              PW      = $clog2(SPS);
    localparam logic [PW-1:0]   LAST_PH = PW'(SPS - 1);

    state_t              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic signed [W-1:0] i_q, i_d, q_q, q_d;
    logic signed [W-1:0] lut_i, lut_q;
    logic                vld_q, vld_d, sym_q, sym_d, und_q, und_d;
    logic                at_last, ready, xfer;

    dqpsk_sym_lut #(.W(W), .AMP(AMP)) u_lut (
        .code_i (bus.in_code),
        .i_o    (lut_i),
        .q_o    (lut_q)
    );

    // Ready depends on state only, so no input reaches any output combinationally.
    assign at_last = (state_q == ST_RUN) && (phase_q == LAST_PH);
    assign ready   = (state_q == ST_IDLE) || at_last;
    assign xfer    = bus.in_valid && ready;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        i_d     = i_q;
        q_d     = q_q;
        vld_d   = vld_q;
        sym_d   = 1'b0;
        und_d   = 1'b0;
        if (xfer) begin
            state_d = ST_RUN;
            phase_d = '0;
            i_d     = lut_i;
            q_d     = lut_q;
            vld_d   = 1'b1;
            sym_d   = 1'b1;
        end else if (at_last) begin
            state_d = ST_IDLE;
            phase_d = '0;
            i_d     = '0;
            q_d     = '0;
            vld_d   = 1'b0;
            und_d   = 1'b1;
        end else if (state_q == ST_RUN) begin
            phase_d = phase_q + PW'(1);
        end else begin
            phase_d = '0;
            i_d     = '0;
            q_d     = '0;
            vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            i_q     <= '0;
            q_q     <= '0;
            vld_q   <= 1'b0;
            sym_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            i_q     <= i_d;
            q_q     <= q_d;
            vld_q   <= vld_d;
            sym_q   <= sym_d;
            und_q   <= und_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.i_out     = i_q;
    assign bus.q_out     = q_q;
    assign bus.out_valid = vld_q;
    assign bus.sym_start = sym_q;
    assign bus.underrun  = und_q;
endmodule

// File: tb/tb_dqpsk_iq_mapper.sv
// Directed + randomized bench for dqpsk_iq_mapper at SPS=8 and SPS=2.
module tb_dqpsk_iq_mapper;
    localparam int W   = 12;
    localparam int AMP = 1448;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] codes8 [8];

    always #5 clk = ~clk;

    dqpsk_iq_mapper_if #(.W(W)) b8 ();
    dqpsk_iq_mapper_if #(.W(W)) b2 ();

    dqpsk_iq_mapper #(.SPS(8), .W(W), .AMP(AMP)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    dqpsk_iq_mapper #(.SPS(2), .W(W), .AMP(AMP)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    // Constellation rule: I is negative for 01/11, Q is negative for 11/10.
    function automatic int exp_i(logic [1:0] c);
        return (c == 2'b01 || c == 2'b11) ? -AMP : AMP;
    endfunction

    function automatic int exp_q(logic [1:0] c);
        return (c == 2'b11 || c == 2'b10) ? -AMP : AMP;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input bit use2, input string tag,
                           input int ei, input int eq, input int ev, input int es, input int eu);
        int oi, oq, ov, os, ou;
        if (use2) begin
            oi = int'(b2.i_out); oq = int'(b2.q_out); ov = int'(b2.out_valid);
            os = int'(b2.sym_start); ou = int'(b2.underrun);
        end else begin
            oi = int'(b8.i_out); oq = int'(b8.q_out); ov = int'(b8.out_valid);
            os = int'(b8.sym_start); ou = int'(b8.underrun);
        end
        chk({tag, ".i"}, oi, ei);
        chk({tag, ".q"}, oq, eq);
        chk({tag, ".valid"}, ov, ev);
        chk({tag, ".sym_start"}, os, es);
        chk({tag, ".underrun"}, ou, eu);
    endtask

    // Streams n symbols from codes8 starting in IDLE; between boundaries the code is
    // scrambled and (optionally) valid is toggled, which must have no effect.
    task automatic run8(input int n, input bit toggle);
        for (int k = 0; k < n * 8; k++) begin
            if (k % 8 == 0) begin
                b8.in_code  = codes8[k / 8];
                b8.in_valid = 1'b1;
            end else begin
                b8.in_code  = 2'($urandom);
                b8.in_valid = toggle ? 1'($urandom) : 1'b1;
            end
            chk("ready8", int'(b8.in_ready), int'(k % 8 == 0));
            tick();
            chk_out(1'b0, "sym8", exp_i(codes8[k / 8]), exp_q(codes8[k / 8]), 1,
                    int'(k % 8 == 0), 0);
        end
        b8.in_valid = 1'b0;
        b8.in_code  = 2'($urandom);
        chk("ready8_last", int'(b8.in_ready), 1);
        tick();
        chk_out(1'b0, "end8", 0, 0, 0, 0, 1);
        tick();
        chk_out(1'b0, "idle8", 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [1:0] taken;
        rst         = 1'b1;
        b8.in_valid = 1'b0;
        b8.in_code  = 2'b00;
        b2.in_valid = 1'b0;
        b2.in_code  = 2'b00;

        repeat (3) tick();
        chk_out(1'b0, "rst8", 0, 0, 0, 0, 0);
        chk_out(1'b1, "rst2", 0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("ready8_rel", int'(b8.in_ready), 1);
        chk("ready2_rel", int'(b2.in_ready), 1);
        tick();
        chk_out(1'b0, "rel8", 0, 0, 0, 0, 0);

        codes8[0] = 2'b00; codes8[1] = 2'b01; codes8[2] = 2'b11; codes8[3] = 2'b10;
        run8(4, 1'b0);

        codes8[0] = 2'b11;
        run8(1, 1'b0);

        for (int i = 0; i < 6; i++) codes8[i] = 2'($urandom);
        run8(6, 1'b1);

        // Reset in the middle of symbol 01.
        b8.in_code  = 2'b01;
        b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        repeat (4) tick();
        chk_out(1'b0, "mid8", -AMP, AMP, 1, 0, 0);
        rst = 1'b1;
        tick();
        chk_out(1'b0, "abort8", 0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("ready8_abort", int'(b8.in_ready), 1);
        tick();
        chk_out(1'b0, "post_abort8", 0, 0, 0, 0, 0);

        // SPS=2: 1000 back-to-back random symbols, code scrambled every cycle.
        taken = 2'b00;
        for (int k = 0; k < 2000; k++) begin
            b2.in_code  = 2'($urandom);
            b2.in_valid = 1'b1;
            if (k % 2 == 0) taken = b2.in_code;
            chk("ready2", int'(b2.in_ready), int'(k % 2 == 0));
            tick();
            chk_out(1'b1, "sym2", exp_i(taken), exp_q(taken), 1, int'(k % 2 == 0), 0);
        end
        b2.in_valid = 1'b0;
        tick();
        chk_out(1'b1, "end2", 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
